// File: rtl/i2s_pkg.sv
// i2s_pkg: shared types and constants for the I2S receiver.
package i2s_pkg;

  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned PAIR_DW     = 16;

  typedef enum logic {
    SYNC,
    RUN
  } rx_state_t;

  typedef struct packed {
    logic [PAIR_DW-1:0] left;
    logic [PAIR_DW-1:0] right;
  } audio_pair_t;

endpackage

// File: rtl/i2s_rx_fifo.sv
// i2s_rx_fifo: synchronous show-ahead FIFO for received stereo pairs.
//   clk, rst_n  : clock, async active-low reset
//   push, wdata : write request / data (a push while full is accepted only with a pop)
//   pop         : remove head entry (ignored when empty)
//   rdata       : head entry
//   full, empty : occupancy flags
module i2s_rx_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  import i2s_pkg::*;

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
  logic             pop_ok, push_ok;

  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign rdata   = mem_q[rd_q[AW-1:0]];

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    if (push_ok) begin
      mem_d[wr_q[AW-1:0]] = wdata;
      wr_d = wr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_d = rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
    end
  end

endmodule

// File: rtl/i2s_rx.sv
// i2s_rx: oversampling I2S receiver, emits one parallel L/R pair per frame.
//   clk_sys, reset_n           : system clock (>= 4x BCK), async active-low reset
//   enable                     : low forces SYNC, drops lock, clears overrun
//   i2s_bck/i2s_lrck/i2s_data  : asynchronous I2S inputs
//   sample_l/sample_r/_valid   : presented pair
//   sample_ready               : consumer accept (FIFO build only)
//   locked, overrun            : frame lock, sticky lost-pair flag
// Optional macro I2S_RX_FIFO_EN adds a FIFO_DEPTH-entry pair FIFO.
module i2s_rx #(
  parameter int unsigned AUDIO_DW   = 16,
  parameter int unsigned TIMEOUT    = 255,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                clk_sys,
  input  logic                reset_n,
  input  logic                enable,
  input  logic                i2s_bck,
  input  logic                i2s_lrck,
  input  logic                i2s_data,
  output logic [AUDIO_DW-1:0] sample_l,
  output logic [AUDIO_DW-1:0] sample_r,
  output logic                sample_valid,
  input  logic                sample_ready,
  output logic                locked,
  output logic                overrun
);
  import i2s_pkg::*;

  localparam int unsigned CW = $clog2(AUDIO_DW + 1);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [AUDIO_DW-1:0] MSB_ONE = {1'b1, {(AUDIO_DW-1){1'b0}}};

  logic [SYNC_STAGES-1:0] bck_sync_q, lrck_sync_q, data_sync_q;
  logic                   bck_prev_q;
  logic                   bck_s, lrck_s, data_s, bck_rise;

  rx_state_t              state_q, state_d;
  logic                   lrck_last_q, lrck_last_d;
  logic                   lrck_seen_q, lrck_seen_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [AUDIO_DW-1:0]    word_q, word_d, word_n;
  logic [AUDIO_DW-1:0]    left_hold_q, left_hold_d;
  logic                   have_left_q, have_left_d;
  logic [TW-1:0]          tmo_q, tmo_d;
  logic                   overrun_q, overrun_d, overrun_set;
  logic                   emit;
  logic [AUDIO_DW-1:0]    emit_l, emit_r;

  assign bck_s    = bck_sync_q[SYNC_STAGES-1];
  assign lrck_s   = lrck_sync_q[SYNC_STAGES-1];
  assign data_s   = data_sync_q[SYNC_STAGES-1];
  assign bck_rise = bck_s & ~bck_prev_q;
  assign locked   = (state_q == RUN);
  assign overrun  = overrun_q;

  always_comb begin
    state_d     = state_q;
    lrck_last_d = lrck_last_q;
    lrck_seen_d = lrck_seen_q;
    cnt_d       = cnt_q;
    word_d      = word_q;
    left_hold_d = left_hold_q;
    have_left_d = have_left_q;
    tmo_d       = tmo_q;
    emit        = 1'b0;
    emit_l      = '0;
    emit_r      = '0;
    // Register is cleared at word start, so OR-ing places the bit at
    // AUDIO_DW-1-count; once count saturates the mask shifts out to zero.
    word_n      = word_q | ({AUDIO_DW{data_s}} & (MSB_ONE >> cnt_q));

    if (!enable) begin
      state_d     = SYNC;
      lrck_seen_d = 1'b0;
      have_left_d = 1'b0;
      tmo_d       = '0;
    end else begin
      case (state_q)
        SYNC: begin
          if (bck_rise) begin
            lrck_last_d = lrck_s;
            lrck_seen_d = 1'b1;
            if (lrck_seen_q && (lrck_s != lrck_last_q)) begin
              state_d     = RUN;
              cnt_d       = '0;
              word_d      = '0;
              have_left_d = 1'b0;
              tmo_d       = '0;
            end
          end
        end
        RUN: begin
          if (bck_rise) begin
            tmo_d = '0;
            if (lrck_s == lrck_last_q) begin
              word_d = word_n;
              if (cnt_q != CW'(AUDIO_DW)) begin
                cnt_d = cnt_q + CW'(1);
              end
            end else begin
              // This edge carries the previous channel's LSB: commit that word.
              if (!lrck_last_q) begin
                left_hold_d = word_n;
                have_left_d = 1'b1;
              end else if (have_left_q) begin
                emit        = 1'b1;
                emit_l      = left_hold_q;
                emit_r      = word_n;
                have_left_d = 1'b0;
              end
              word_d      = '0;
              cnt_d       = '0;
              lrck_last_d = lrck_s;
            end
          end else if (tmo_q == TW'(TIMEOUT - 1)) begin
            state_d     = SYNC;
            lrck_seen_d = 1'b0;
            have_left_d = 1'b0;
            tmo_d       = '0;
          end else begin
            tmo_d = tmo_q + TW'(1);
          end
        end
        default: state_d = SYNC;
      endcase
    end

    overrun_d = enable ? (overrun_q | overrun_set) : 1'b0;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      bck_sync_q  <= '0;
      lrck_sync_q <= '0;
      data_sync_q <= '0;
      bck_prev_q  <= 1'b0;
      state_q     <= SYNC;
      lrck_last_q <= 1'b0;
      lrck_seen_q <= 1'b0;
      cnt_q       <= '0;
      word_q      <= '0;
      left_hold_q <= '0;
      have_left_q <= 1'b0;
      tmo_q       <= '0;
      overrun_q   <= 1'b0;
    end else begin
      bck_sync_q  <= {bck_sync_q[SYNC_STAGES-2:0], i2s_bck};
      lrck_sync_q <= {lrck_sync_q[SYNC_STAGES-2:0], i2s_lrck};
      data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], i2s_data};
      bck_prev_q  <= bck_s;
      state_q     <= state_d;
      lrck_last_q <= lrck_last_d;
      lrck_seen_q <= lrck_seen_d;
      cnt_q       <= cnt_d;
      word_q      <= word_d;
      left_hold_q <= left_hold_d;
      have_left_q <= have_left_d;
      tmo_q       <= tmo_d;
      overrun_q   <= overrun_d;
    end
  end

`ifdef I2S_RX_FIFO_EN
  logic                  fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [2*AUDIO_DW-1:0] fifo_rdata;

  // A pop in the same cycle frees space, so the emit is still accepted.
  assign fifo_pop    = ~fifo_empty & sample_ready;
  assign fifo_push   = emit & (~fifo_full | fifo_pop);
  assign overrun_set = emit & ~fifo_push;

  i2s_rx_fifo #(
    .WIDTH (2 * AUDIO_DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk_sys),
    .rst_n (reset_n),
    .push  (fifo_push),
    .wdata ({emit_l, emit_r}),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign sample_valid = ~fifo_empty;
  assign sample_l     = fifo_rdata[2*AUDIO_DW-1:AUDIO_DW];
  assign sample_r     = fifo_rdata[AUDIO_DW-1:0];
`else
  logic [AUDIO_DW-1:0] sample_l_q, sample_l_d, sample_r_q, sample_r_d;
  logic                valid_q, valid_d;
  logic                unused_cfg;

  assign unused_cfg  = sample_ready | (FIFO_DEPTH == 0);
  assign overrun_set = emit & valid_q;

  always_comb begin
    sample_l_d = sample_l_q;
    sample_r_d = sample_r_q;
    valid_d    = emit;
    if (emit) begin
      sample_l_d = emit_l;
      sample_r_d = emit_r;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      sample_l_q <= '0;
      sample_r_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      sample_l_q <= sample_l_d;
      sample_r_q <= sample_r_d;
      valid_q    <= valid_d;
    end
  end

  assign sample_valid = valid_q;
  assign sample_l     = sample_l_q;
  assign sample_r     = sample_r_q;
`endif

endmodule

// File: tb/tb_i2s_rx.sv
`timescale 1ns/1ps
module tb_i2s_rx;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        i2s_bck = 1'b0;
  logic        i2s_lrck = 1'b1;
  logic        i2s_data = 1'b0;
  logic        sample_ready = 1'b1;
  logic [15:0] sample_l, sample_r;
  logic        sample_valid, locked, overrun;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] sb [$];
  logic        prev_bit = 1'b0;
  logic        prev_valid = 1'b0;
  logic [31:0] exp_pair;

  i2s_rx #(
    .AUDIO_DW   (16),
    .TIMEOUT    (255),
    .FIFO_DEPTH (4)
  ) dut (
    .clk_sys      (clk_sys),
    .reset_n      (reset_n),
    .enable       (enable),
    .i2s_bck      (i2s_bck),
    .i2s_lrck     (i2s_lrck),
    .i2s_data     (i2s_data),
    .sample_l     (sample_l),
    .sample_r     (sample_r),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .locked       (locked),
    .overrun      (overrun)
  );

  // 32 MHz system clock
  always #15.625 clk_sys = ~clk_sys;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One BCK period (~3.07 MHz). Data lags LRCK by one bit: the wire carries
  // the previous sequence bit, giving the standard I2S one-bit delay.
  task automatic bck_bit(input logic lr, input logic seq_bit);
    i2s_lrck = lr;
    i2s_data = prev_bit;
    prev_bit = seq_bit;
    i2s_bck  = 1'b0;
    #163;
    i2s_bck  = 1'b1;
    #163;
  endtask

  // word is left-justified in 32 bits, MSB first
  task automatic send_slot(input logic lr, input logic [31:0] word, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      bck_bit(lr, word[31-i]);
    end
  endtask

  task automatic send_frame(input logic [31:0] l32, input logic [31:0] r32, input int slot,
                            input logic expect_pair, input logic [31:0] exp);
    if (expect_pair) sb.push_back(exp);
    send_slot(1'b0, l32, slot);
    send_slot(1'b1, r32, slot);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk_sys);
`ifdef I2S_RX_FIFO_EN
        if (reset_n && sample_valid && sample_ready) begin
`else
        if (reset_n && sample_valid) begin
`endif
          if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_pair: got %h/%h expected none", sample_l, sample_r);
          end else begin
            exp_pair = sb.pop_front();
            check("pair_left", {16'h0, sample_l}, {16'h0, exp_pair[31:16]});
            check("pair_right", {16'h0, sample_r}, {16'h0, exp_pair[15:0]});
          end
`ifndef I2S_RX_FIFO_EN
          check("valid_strobe", {31'h0, prev_valid}, 32'h0);
`endif
        end
        prev_valid = sample_valid;
      end
    join_none

    // reset values
    wait_cycles(5);
    check("rst_sample_l", {16'h0, sample_l}, 32'h0);
    check("rst_sample_r", {16'h0, sample_r}, 32'h0);
    check("rst_valid", {31'h0, sample_valid}, 32'h0);
    check("rst_locked", {31'h0, locked}, 32'h0);
    check("rst_overrun", {31'h0, overrun}, 32'h0);
    reset_n = 1'b1;
    enable  = 1'b1;
    wait_cycles(5);

    // lock acquisition: stream starts mid-right-word
    send_slot(1'b1, 32'hDEAD_BEEF, 10);
    check("no_lock_partial", {31'h0, locked}, 32'h0);
    send_frame(32'h1234_0000, 32'hABCD_0000, 32, 1'b1, 32'h1234_ABCD);
    check("locked_after_change", {31'h0, locked}, 32'h1);

    // 24-bit words truncated; 12-bit words left-justified
    send_frame(32'h8765_4300, 32'h00FF_0000, 32, 1'b1, 32'h8765_00FF);
    send_frame(32'hFFF0_0000, 32'hA5C0_0000, 12, 1'b1, 32'hFFF0_A5C0);
    send_slot(1'b0, 32'h0, 4);

    // timeout with BCK stopped
    wait_cycles(240);
    check("lock_before_timeout", {31'h0, locked}, 32'h1);
    wait_cycles(30);
    check("lock_after_timeout", {31'h0, locked}, 32'h0);
    check("pair_kept_l", {16'h0, sample_l}, 32'hFFF0);

    // restart mid-frame: right word after relock has no left and is dropped
    send_slot(1'b0, 32'hFFFF_FFFF, 10);
    send_slot(1'b1, 32'h5555_0000, 32);
    check("relocked", {31'h0, locked}, 32'h1);
    send_frame(32'h3C3C_0000, 32'hC3C3_0000, 32, 1'b1, 32'h3C3C_C3C3);
    send_slot(1'b0, 32'h0, 4);
    wait_cycles(5);

    // async reset mid-word
    send_slot(1'b0, 32'h1111_0000, 32);
    send_slot(1'b1, 32'h2222_0000, 8);
    reset_n = 1'b0;
    #5;
    check("midrst_sample_l", {16'h0, sample_l}, 32'h0);
    check("midrst_sample_r", {16'h0, sample_r}, 32'h0);
    check("midrst_valid", {31'h0, sample_valid}, 32'h0);
    check("midrst_locked", {31'h0, locked}, 32'h0);
    check("midrst_overrun", {31'h0, overrun}, 32'h0);
    wait_cycles(3);
    reset_n = 1'b1;
    send_slot(1'b1, 32'h2222_0000, 24);
    check("no_lock_after_rst", {31'h0, locked}, 32'h0);
    send_frame(32'h0F0F_0000, 32'hF0F0_0000, 32, 1'b1, 32'h0F0F_F0F0);
    send_slot(1'b0, 32'h0, 4);
    wait_cycles(10);

`ifdef I2S_RX_FIFO_EN
    // 6 frames with the consumer stalled: only the first 4 survive
    sample_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      send_frame({16'h1000 + 16'(i), 16'h0}, {16'h2000 + 16'(i), 16'h0}, 32,
                 (i < 4), {16'h1000 + 16'(i), 16'h2000 + 16'(i)});
    end
    send_slot(1'b0, 32'h0, 4);
    wait_cycles(5);
    check("fifo_overrun", {31'h0, overrun}, 32'h1);
    check("fifo_full_valid", {31'h0, sample_valid}, 32'h1);
    sample_ready = 1'b1;
    wait_cycles(20);
`endif

    // enable low drops lock and clears overrun
    enable = 1'b0;
    wait_cycles(4);
    check("dis_locked", {31'h0, locked}, 32'h0);
    check("dis_overrun", {31'h0, overrun}, 32'h0);

    wait_cycles(10);
    check("sb_drained", sb.size(), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
